// File: rtl/n_way_sum_using_fifos_and_double_buffer_pkg.sv
// Shared constants, types and helpers for the n-way FIFO summing block.
package n_way_sum_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEPTH    = 10;
  localparam int DEFAULT_N_INPUTS = 3;
  localparam int DEFAULT_SATURATE = 0;
  localparam int STATS_W          = 32;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  // Result width: saturating mode keeps the operand width, otherwise the
  // sum grows by enough bits to hold n_inputs maximal operands.
  function automatic int sum_out_width(input int width, input int n_inputs,
                                       input int saturate);
    if (saturate != 0) begin
      return width;
    end else begin
      return width + $clog2(n_inputs);
    end
  endfunction

endpackage

// File: rtl/n_way_sum_using_fifos_and_double_buffer_if.sv
// Handshake bundle: n_inputs valid/ready input channels and one sum output.
// master = traffic source/sink side, slave = the summing block.
interface n_way_sum_using_fifos_and_double_buffer_if #(
  parameter int width     = 8,
  parameter int n_inputs  = 3,
  parameter int out_width = 10
);
  logic [n_inputs-1:0]       in_valid;
  logic [n_inputs-1:0]       in_ready;
  logic [n_inputs*width-1:0] in_data;
  logic                      sum_valid;
  logic                      sum_ready;
  logic [out_width-1:0]      sum_data;

  modport master (
    output in_valid, in_data, sum_ready,
    input  in_ready, sum_valid, sum_data
  );

  modport slave (
    input  in_valid, in_data, sum_ready,
    output in_ready, sum_valid, sum_data
  );
endinterface

// File: rtl/double_buffer_from_dally_harting.sv
// Two-entry in-order output buffer: an output register plus one skid
// register. down_valid, down_data and up_ready are all registered, so the
// upstream ready never depends combinationally on down_ready.
module double_buffer_from_dally_harting
  import n_way_sum_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [width-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [width-1:0] down_data
);
  buf_state_t       state;
  logic [width-1:0] skid;
  logic             push;
  logic             pop;

  assign push = up_valid & up_ready;
  assign pop  = down_valid & down_ready;

  // Occupancy FSM; every output is updated alongside the state it reflects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BUF_EMPTY;
      down_data  <= {width{1'b0}};
      skid       <= {width{1'b0}};
      down_valid <= 1'b0;
      up_ready   <= 1'b1;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (push) begin
            down_data  <= up_data;
            down_valid <= 1'b1;
            state      <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({push, pop})
            2'b10: begin
              skid     <= up_data;
              up_ready <= 1'b0;
              state    <= BUF_FULL;
            end
            2'b01: begin
              down_valid <= 1'b0;
              state      <= BUF_EMPTY;
            end
            2'b11: begin
              down_data <= up_data;
            end
            default: begin
              state <= BUF_ONE;
            end
          endcase
        end
        BUF_FULL: begin
          // up_ready is low here, so only the drain side can move.
          if (pop) begin
            down_data <= skid;
            up_ready  <= 1'b1;
            state     <= BUF_ONE;
          end
        end
        default: begin
          down_valid <= 1'b0;
          up_ready   <= 1'b1;
          state      <= BUF_EMPTY;
        end
      endcase
    end
  end
endmodule

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-array FIFO tracked by an occupancy counter. Head is read
// combinationally, so a push is visible at out_data the following cycle.
// Pushes into a full FIFO and pops from an empty one are ignored.
module flip_flop_fifo_with_counter #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] in_data,
  output logic [width-1:0] out_data,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(depth - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth);

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full     = (count == FULL_CNT);
  assign empty    = (count == {CNT_W{1'b0}});
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign out_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, cleared on reset so stale data never reaches the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= {width{1'b0}};
      end
    end else if (do_push) begin
      mem[wr_ptr] <= in_data;
    end
  end
endmodule

// File: rtl/n_way_sum_using_fifos_and_double_buffer_join.sv
// Join stage: pops every FIFO together once all are non-empty and the
// output buffer has room, and forms the (optionally saturated) sum.
module n_way_sum_join
  import n_way_sum_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int n_inputs  = DEFAULT_N_INPUTS,
  parameter int saturate  = DEFAULT_SATURATE,
  parameter int out_width = sum_out_width(width, n_inputs, saturate)
) (
  input  logic [n_inputs-1:0]       empty,
  input  logic [n_inputs*width-1:0] heads,
  input  logic                      up_ready,
  output logic [n_inputs-1:0]       pop,
  output logic                      up_valid,
  output logic [out_width-1:0]      up_data
);
  localparam int SUM_W = width + $clog2(n_inputs);

  logic             fire;
  logic [SUM_W-1:0] wide;

  // All channels advance together; no channel is ever popped alone.
  always_comb begin
    fire     = (&(~empty)) & up_ready;
    pop      = {n_inputs{fire}};
    up_valid = fire;
  end

  // Full-precision unsigned sum of the FIFO heads (cannot overflow SUM_W).
  always_comb begin
    wide = {SUM_W{1'b0}};
    for (int i = 0; i < n_inputs; i++) begin
      wide = wide + SUM_W'(heads[i*width +: width]);
    end
  end

  if (saturate != 0) begin : g_sat
    localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'({width{1'b1}});
    // Clamp to the largest width-bit value.
    always_comb begin
      if (wide > MAX_VAL) begin
        up_data = {width{1'b1}};
      end else begin
        up_data = wide[width-1:0];
      end
    end
  end else begin : g_wrap
    assign up_data = wide;
  end
endmodule

// File: rtl/n_way_sum_using_fifos_and_double_buffer.sv
// n-way stream adder: one FIFO per input channel, a join that sums one
// entry from every FIFO, and a two-entry output buffer.
// Optional build macro N_WAY_SUM_STATS_EN adds a 32-bit sum_count port
// counting downstream handshakes.
module n_way_sum_using_fifos_and_double_buffer
  import n_way_sum_pkg::*;
#(
  parameter int width    = DEFAULT_WIDTH,
  parameter int depth    = DEFAULT_DEPTH,
  parameter int n_inputs = DEFAULT_N_INPUTS,
  parameter int saturate = DEFAULT_SATURATE
) (
  input  logic clk,
  input  logic rst,
  n_way_sum_using_fifos_and_double_buffer_if.slave bus
`ifdef N_WAY_SUM_STATS_EN
  ,
  output logic [STATS_W-1:0] sum_count
`endif
);
  localparam int out_width = sum_out_width(width, n_inputs, saturate);

  logic [n_inputs-1:0]       fifo_empty;
  logic [n_inputs-1:0]       fifo_full;
  logic [n_inputs-1:0]       push;
  logic [n_inputs-1:0]       pop;
  logic [n_inputs*width-1:0] heads;
  logic                      buf_up_ready;
  logic                      up_valid;
  logic [out_width-1:0]      up_data;

  // Ready reflects only FIFO space; a full FIFO refuses even when popping.
  assign bus.in_ready = ~fifo_full;
  assign push         = bus.in_valid & ~fifo_full;

  for (genvar i = 0; i < n_inputs; i++) begin : g_ch
    flip_flop_fifo_with_counter #(
      .width (width),
      .depth (depth)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .pop      (pop[i]),
      .in_data  (bus.in_data[i*width +: width]),
      .out_data (heads[i*width +: width]),
      .empty    (fifo_empty[i]),
      .full     (fifo_full[i])
    );
  end

  n_way_sum_join #(
    .width     (width),
    .n_inputs  (n_inputs),
    .saturate  (saturate),
    .out_width (out_width)
  ) u_join (
    .empty    (fifo_empty),
    .heads    (heads),
    .up_ready (buf_up_ready),
    .pop      (pop),
    .up_valid (up_valid),
    .up_data  (up_data)
  );

  double_buffer_from_dally_harting #(
    .width (out_width)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (buf_up_ready),
    .up_data    (up_data),
    .down_valid (bus.sum_valid),
    .down_ready (bus.sum_ready),
    .down_data  (bus.sum_data)
  );

`ifdef N_WAY_SUM_STATS_EN
  // Count completed output handshakes; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_count <= {STATS_W{1'b0}};
    end else if (bus.sum_valid & bus.sum_ready) begin
      sum_count <= sum_count + STATS_W'(1);
    end else begin
      sum_count <= sum_count;
    end
  end
`endif
endmodule
